// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-at-a-time drive, full-map debounce,
// registered digit vector / lowest-code key outputs with a change strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_DWELL     = 12500,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [9:0] key_vector,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe,
  output logic       multi_key
);

  localparam int unsigned DW = $clog2(SCAN_DWELL);
  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE_ST, DRIVE_ST, SAMPLE_ST, COMPARE_ST} state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [3:0]    rows;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   last_q, last_d;
  logic [15:0]   map_q, map_d;
  logic [SW-1:0] stable_q, stable_d, stable_next;

  logic [9:0]    vec_q, vec_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          multi_q, multi_d;
  logic [15:0]   by_code;

  assign rows = ~row_s2_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      state_q  <= IDLE_ST;
      col_q    <= '0;
      dwell_q  <= '0;
      snap_q   <= '0;
      last_q   <= '0;
      map_q    <= '0;
      stable_q <= '0;
      vec_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      state_q  <= state_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      snap_q   <= snap_d;
      last_q   <= last_d;
      map_q    <= map_d;
      stable_q <= stable_d;
      vec_q    <= vec_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      multi_q  <= multi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    snap_d      = snap_q;
    last_d      = last_q;
    map_d       = map_q;
    stable_d    = stable_q;
    stable_next = '0;
    if (!enable) begin
      // Partial snapshot is simply overwritten by the next full scan.
      state_d  = IDLE_ST;
      stable_d = '0;
    end else begin
      case (state_q)
        IDLE_ST: begin
          col_d   = '0;
          dwell_d = '0;
          state_d = DRIVE_ST;
        end
        DRIVE_ST: begin
          if (dwell_q == DWELL_LAST) state_d = SAMPLE_ST;
          else                       dwell_d = dwell_q + 1'b1;
        end
        SAMPLE_ST: begin
          for (int unsigned r = 0; r < 4; r++) snap_d[{2'(r), col_q}] = rows[r];
          if (col_q == 2'd3) begin
            state_d = COMPARE_ST;
          end else begin
            col_d   = col_q + 1'b1;
            dwell_d = '0;
            state_d = DRIVE_ST;
          end
        end
        COMPARE_ST: begin
          if (snap_q == last_q)
            stable_next = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
          else
            stable_next = SW'(1);
          stable_d = stable_next;
          if (stable_next == STABLE_MAX) map_d = snap_q;
          last_d  = snap_q;
          col_d   = '0;
          dwell_d = '0;
          state_d = DRIVE_ST;
        end
        default: state_d = IDLE_ST;
      endcase
    end
  end

  always_comb begin
    col_n = '1;
    if (state_q == DRIVE_ST || state_q == SAMPLE_ST) col_n = ~(4'b0001 << col_q);
  end

  // by_code[c] is set when the key whose code is c is pressed; bits 9:0 double as the digit vector.
  always_comb begin
    vec_d[0] = map_q[13];
    vec_d[1] = map_q[0];
    vec_d[2] = map_q[1];
    vec_d[3] = map_q[2];
    vec_d[4] = map_q[4];
    vec_d[5] = map_q[5];
    vec_d[6] = map_q[6];
    vec_d[7] = map_q[8];
    vec_d[8] = map_q[9];
    vec_d[9] = map_q[10];
    by_code  = {map_q[14], map_q[12], map_q[15], map_q[11], map_q[7], map_q[3], vec_d};
    valid_d  = |map_q;
    multi_d  = |(map_q & (map_q - 16'd1));
    code_d   = code_q;
    for (int unsigned c = 16; c > 0; c--) begin
      if (by_code[c-1]) code_d = 4'(c - 1);
    end
    strobe_d = valid_d && (!valid_q || (code_d != code_q));
  end

  assign key_vector = vec_q;
  assign key_code   = code_q;
  assign key_valid  = valid_q;
  assign key_strobe = strobe_q;
  assign multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a diode-free keypad model drives the
// rows; fixed vectors, corner-case sequences and random key sets are checked.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [9:0] key_vector;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;
  logic       multi_key;

  logic [15:0] keys;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam int unsigned HOLD = 100;

  keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE_SCANS(3)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .enable     (enable),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_vector (key_vector),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low whenever its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    logic [9:0]  vec;
    logic [3:0]  code;
    logic        valid;
    logic        multi;
    int unsigned strobes;
  } vec_t;

  vec_t tbl[10];
  int unsigned code_of[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int unsigned n, output int unsigned strobes);
    strobes = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (key_strobe) strobes++;
    end
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (col_n == pat) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic model(input logic [15:0] k, input logic [3:0] prev_code,
                       output logic [9:0] v, output logic [3:0] code,
                       output logic valid, output logic multi);
    int unsigned n;
    int unsigned best;
    n = 0; best = 16; v = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) begin
        n++;
        if (code_of[i] < best) best = code_of[i];
        if (code_of[i] < 10) v[code_of[i]] = 1'b1;
      end
    end
    valid = (n > 0);
    multi = (n > 1);
    code  = valid ? 4'(best) : prev_code;
  endtask

  task automatic apply(input vec_t t, input string tag);
    int unsigned s;
    keys = t.keys;
    hold(HOLD, s);
    check({tag, ".vector"},  32'(key_vector), 32'(t.vec));
    check({tag, ".code"},    32'(key_code),   32'(t.code));
    check({tag, ".valid"},   32'(key_valid),  32'(t.valid));
    check({tag, ".multi"},   32'(multi_key),  32'(t.multi));
    check({tag, ".strobes"}, s,               t.strobes);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned s;
    int unsigned cyc;
    logic        seen;
    logic        prev_valid;
    logic [3:0]  prev_code;
    vec_t        t;

    tbl[0] = '{16'h0000, 10'h000, 4'd0,  1'b0, 1'b0, 0};
    tbl[1] = '{16'h0020, 10'h020, 4'd5,  1'b1, 1'b0, 1};
    tbl[2] = '{16'h0000, 10'h000, 4'd5,  1'b0, 1'b0, 0};
    tbl[3] = '{16'h0042, 10'h044, 4'd2,  1'b1, 1'b1, 1};
    tbl[4] = '{16'h0040, 10'h040, 4'd6,  1'b1, 1'b0, 1};
    tbl[5] = '{16'h4000, 10'h000, 4'd15, 1'b1, 1'b0, 1};
    tbl[6] = '{16'h0000, 10'h000, 4'd15, 1'b0, 1'b0, 0};
    tbl[7] = '{16'h3000, 10'h001, 4'd0,  1'b1, 1'b1, 1};
    tbl[8] = '{16'h8008, 10'h000, 4'd10, 1'b1, 1'b1, 1};
    tbl[9] = '{16'h0000, 10'h000, 4'd10, 1'b0, 1'b0, 0};

    keys = '0; enable = 1'b1; resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.col_n", 32'(col_n),      32'hF);
    check("reset.valid", 32'(key_valid),  32'd0);
    check("reset.code",  32'(key_code),   32'd0);
    check("reset.vec",   32'(key_vector), 32'd0);
    @(negedge clk); resetN = 1'b1;

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Bounce on key 8: pressed, dropped, pressed again.
    seen = 1'b0;
    keys = 16'h0200;
    repeat (30) begin @(posedge clk); #1; seen |= key_valid; end
    keys = 16'h0000;
    repeat (30) begin @(posedge clk); #1; seen |= key_valid; end
    keys = 16'h0200;
    s = 0;
    repeat (42) begin @(posedge clk); #1; seen |= key_valid; if (key_strobe) s++; end
    check("bounce.no_early_valid", 32'(seen), 32'd0);
    hold(80, cyc);
    s += cyc;
    check("bounce.code",    32'(key_code),   32'd8);
    check("bounce.vec",     32'(key_vector), 32'h100);
    check("bounce.strobes", s,               1);

    // Enable dropped during the column-2 dwell.
    t = '{16'h0001, 10'h002, 4'd1, 1'b1, 1'b0, 1};
    apply(t, "en_pre");
    wait_col(4'b1011, "en.wait_col2");
    enable = 1'b0;
    @(posedge clk); #1;
    check("en.col_released", 32'(col_n), 32'hF);
    keys = 16'h0400;
    hold(60, s);
    check("en.hold_code",    32'(key_code),   32'd1);
    check("en.hold_vec",     32'(key_vector), 32'h002);
    check("en.hold_strobes", s,               0);
    enable = 1'b1;
    seen = 1'b0; s = 0;
    for (cyc = 1; cyc <= 48; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 2 && col_n == 4'b1110) seen = 1'b1;
      if (key_strobe) s++;
    end
    check("en.restart_col0",  32'(seen),     32'd1);
    check("en.debounce_code", 32'(key_code), 32'd1);
    check("en.debounce_strb", s,             0);
    hold(60, s);
    check("en.new_code",    32'(key_code),   32'd9);
    check("en.new_vec",     32'(key_vector), 32'h200);
    check("en.new_strobes", s,               1);

    // Reset in the middle of a column-1 drive.
    wait_col(4'b1101, "rst.wait_col1");
    resetN = 1'b0;
    keys = '0;
    #1;
    check("rst.col_n", 32'(col_n),      32'hF);
    check("rst.valid", 32'(key_valid),  32'd0);
    check("rst.code",  32'(key_code),   32'd0);
    check("rst.vec",   32'(key_vector), 32'd0);
    check("rst.multi", 32'(multi_key),  32'd0);
    @(negedge clk); resetN = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (col_n == 4'b1110) seen = 1'b1; end
    check("rst.restart_col0", 32'(seen), 32'd1);

    // Random key sets against the reference model.
    prev_valid = 1'b0; prev_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      t.keys = '0;
      repeat ($urandom_range(0, 3)) t.keys[$urandom_range(0, 15)] = 1'b1;
      model(t.keys, prev_code, t.vec, t.code, t.valid, t.multi);
      t.strobes = (t.valid && (!prev_valid || t.code != prev_code)) ? 1 : 0;
      apply(t, $sformatf("rand%0d", i));
      prev_valid = t.valid;
      prev_code  = t.code;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
